// File: rtl/hamming_serial_tx.sv
// Serial transmitter for Hamming codewords.
// Sends start bit, N data bits (bit 0 first), stop bit.
module hamming_serial_tx #(
  parameter int N   = 7,
  parameter int DIV = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [0:N-1] word_in,
  input  logic         load,
  output logic         tx,
  output logic         busy,
  output logic         done,
  output logic         overrun
);

  localparam int IW = $clog2(N + 1);
  localparam int DW = $clog2(DIV + 1);

  localparam logic [IW-1:0] ILAST = IW'(N - 1);
  localparam logic [DW-1:0] DLAST = DW'(DIV - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    state;
  logic [0:N-1]  shreg;
  logic [IW-1:0] idx;
  logic [DW-1:0] div;
  logic [IW-1:0] nidx;
  logic [DW-1:0] dnext;
  logic          bit_end;

  assign nidx    = idx + 1'b1;
  assign dnext   = div + 1'b1;
  assign bit_end = (div == DLAST);

  // Frame sequencer; tx/busy/done are computed one cycle
  // ahead so every output comes straight from a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      idx   <= '0;
      div   <= '0;
      tx    <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            shreg <= word_in;
            state <= START;
            div   <= '0;
            idx   <= '0;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            div   <= '0;
            idx   <= '0;
            state <= DATA;
            tx    <= shreg[0];
          end else begin
            div <= dnext;
          end
        end
        DATA: begin
          if (bit_end) begin
            div <= '0;
            if (idx == ILAST) begin
              state <= STOP;
              tx    <= 1'b1;
              // a one-cycle stop bit is also its last cycle
              done  <= (DLAST == '0);
            end else begin
              idx <= nidx;
              tx  <= shreg[nidx];
            end
          end else begin
            div <= dnext;
          end
        end
        default: begin
          if (bit_end) begin
            div   <= '0;
            state <= IDLE;
            tx    <= 1'b1;
            busy  <= 1'b0;
          end else begin
            div  <= dnext;
            done <= (dnext == DLAST);
          end
        end
      endcase
    end
  end

  // Sticky flag for a load that arrived while a frame was running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (load && busy) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_serial_tx.sv
// Scoreboard bench for hamming_serial_tx.
// Runs a DIV=2 and a DIV=1 instance side by side.
module tb_hamming_serial_tx;

  typedef struct {
    logic tx;
    logic busy;
    logic done;
    logic ovr;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [0:6] word_in;
  logic       load2, load1;
  logic       tx2, busy2, done2, overrun2;
  logic       tx1, busy1, done1, overrun1;

  exp_t q2[$];
  exp_t q1[$];
  bit   ov2, ov1;

  int total = 0;
  int bad   = 0;

  hamming_serial_tx #(.N(7), .DIV(2)) u2 (
    .clk(clk), .reset(reset), .word_in(word_in), .load(load2),
    .tx(tx2), .busy(busy2), .done(done2), .overrun(overrun2)
  );

  hamming_serial_tx #(.N(7), .DIV(1)) u1 (
    .clk(clk), .reset(reset), .word_in(word_in), .load(load1),
    .tx(tx1), .busy(busy1), .done(done1), .overrun(overrun1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare one expected cycle per instance, 1 time unit after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q2.size() > 0) begin
      e = q2.pop_front();
      chk("tx2", tx2, e.tx);
      chk("busy2", busy2, e.busy);
      chk("done2", done2, e.done);
      chk("ovr2", overrun2, e.ovr);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("tx1", tx1, e.tx);
      chk("busy1", busy1, e.busy);
      chk("done1", done1, e.done);
      chk("ovr1", overrun1, e.ovr);
    end
  end

  // Called at a negedge; returns at the negedge of the idle cycle
  // after the frame, where a back-to-back load is legal.
  // ea/eb: frame cycles (1-based) in which a spurious load is driven.
  task automatic send(input bit sel, input logic [0:6] w,
                      input int ea, input int eb);
    int   d;
    int   len;
    int   pos;
    bit   ov;
    exp_t e;
    d   = sel ? 1 : 2;
    len = 9 * d;
    ov  = sel ? ov1 : ov2;
    word_in = w;
    load1 = sel;
    load2 = !sel;
    for (int k = 1; k <= len + 1; k++) begin
      pos = (k - 1) / d;
      if (k > len)       e.tx = 1'b1;
      else if (pos == 0) e.tx = 1'b0;
      else if (pos <= 7) e.tx = w[pos-1];
      else               e.tx = 1'b1;
      e.busy = (k <= len);
      e.done = (k == len);
      e.ovr  = ov || (ea != 0 && k > ea);
      if (sel) q1.push_back(e);
      else     q2.push_back(e);
    end
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk);
      word_in = 7'($urandom);
      load1 = sel && (k == ea || k == eb);
      load2 = !sel && (k == ea || k == eb);
    end
    if (ea != 0) begin
      if (sel) ov1 = 1'b1;
      else     ov2 = 1'b1;
    end
  endtask

  initial begin
    reset   = 1'b1;
    load1   = 1'b0;
    load2   = 1'b0;
    word_in = '0;
    ov1     = 1'b0;
    ov2     = 1'b0;
    #12 reset = 1'b0;

    // reset state held while idle
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("idle_tx", {tx2, tx1}, 2'b11);
      chk("idle_busy", {busy2, busy1}, 2'b00);
      chk("idle_done", {done2, done1}, 2'b00);
      chk("idle_ovr", {overrun2, overrun1}, 2'b00);
    end
    @(negedge clk);

    // basic frame, then back-to-back in the first idle cycle
    send(1'b0, 7'b1011010, 0, 0);
    send(1'b0, 7'b0000001, 0, 0);
    repeat (3) @(negedge clk);

    // spurious loads during bits 2 and 5
    send(1'b0, 7'b0110011, 7, 13);
    repeat (2) @(negedge clk);
    chk("ovr_sticky", overrun2, 1'b1);

    // async reset in the middle of data bit 3
    word_in = 7'b1110001;
    load2   = 1'b1;
    @(negedge clk);
    load2 = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_busy", busy2, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rst_tx", tx2, 1'b1);
    chk("rst_busy", busy2, 1'b0);
    chk("rst_ovr", overrun2, 1'b0);
    #1 reset = 1'b0;
    ov2 = 1'b0;
    @(negedge clk);
    send(1'b0, 7'b1110001, 0, 0);
    repeat (2) @(negedge clk);

    // one bit per cycle
    send(1'b1, 7'b1111111, 0, 0);
    send(1'b1, 7'b0101100, 0, 0);
    send(1'b1, 7'b1001011, 4, 0);
    repeat (3) @(negedge clk);

    chk("q2_empty", q2.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
